twophase_sequencer: RTL
=======================

Name: twophase_sequencer

Overview:
- Programmable digital two-phase non-overlapping clock sequencer for the imager's pixel modulation clocks.
- Derives PHI1/PHI2 from the system clock with a programmable high time per phase and a programmable dead time. Generates a finite burst or runs continuously.
- Uses a start/stop/done handshake so the readout controller can frame each exposure.
- Replaces the fixed gate-delay non-overlap scheme with cycle-accurate, configurable timing.

Parameters:
- CNT_W, 8, width of the phase and gap length fields (cycles)
- BURST_W, 16, width of the burst cycle count and the progress counter

Ports:
- CLK_IN  input  1  system clock; all logic on the rising edge
- RST_N  input  1  asynchronous active-low reset
- START  input  1  level-sampled; begins a burst when sampled high in IDLE
- STOP  input  1  level-sampled; aborts a running burst
- PH1_LEN  input  CNT_W  PHI1 high time in cycles
- PH2_LEN  input  CNT_W  PHI2 high time in cycles
- GAP_LEN  input  CNT_W  dead time in cycles, inserted after each phase
- NUM_CYCLES  input  BURST_W  full periods per burst; 0 means continuous
- PHI1  output  1  phase-1 clock, registered
- PHI2  output  1  phase-2 clock, registered
- BUSY  output  1  high in any state other than IDLE
- DONE  output  1  one-cycle pulse when a burst ends, normally or by STOP
- CYCLE_CNT  output  BURST_W  completed full periods in the current or last burst

Behaviour:
- Reset: RST_N low asynchronously forces state=IDLE and PHI1=PHI2=BUSY=DONE=0. CYCLE_CNT and all internal counters clear to 0. Reset mid-burst drops both phases immediately, with no trailing gap.
- States: IDLE, PH1, GAP1, PH2, GAP2, ABORT.
- Configuration capture: PH1_LEN, PH2_LEN, GAP_LEN and NUM_CYCLES latch on the edge where START is accepted. Input changes during a burst have no effect.
- Zero clamp: a latched length of 0 is treated as 1. GAP_LEN is therefore at least 1, which guarantees PHI1 and PHI2 are never high in the same cycle.
- Start: START=1 and STOP=0 sampled in IDLE at edge t0.
  - From t0: PHI1=1, BUSY=1, CYCLE_CNT=0, state=PH1.
  - START is ignored while BUSY.
  - START and STOP both high in IDLE: nothing starts.
- Sequence (outputs registered, so state and output change on the same edge):
  - PH1: PHI1=1 for exactly PH1_LEN cycles, then GAP1.
  - GAP1: both phases low for GAP_LEN cycles, then PH2.
  - PH2: PHI2=1 for PH2_LEN cycles, then GAP2.
  - GAP2: both low for GAP_LEN cycles. On its final cycle, CYCLE_CNT increments.
  - Exit from GAP2: if NUM_CYCLES!=0 and the incremented count equals NUM_CYCLES, go to IDLE. Otherwise go to PH1.
- Period: PH1_LEN + PH2_LEN + 2*GAP_LEN cycles, all after clamping.
- Normal end: on the edge entering IDLE, DONE=1 for one cycle and BUSY=0. CYCLE_CNT holds its value until the next accepted START.
- Continuous mode (NUM_CYCLES=0):
  - Runs until STOP.
  - CYCLE_CNT wraps modulo 2^BURST_W without stopping.
- Abort: STOP sampled high in PH1, GAP1, PH2 or GAP2.
  - Next edge: PHI1=PHI2=0, state=ABORT.
  - ABORT holds both phases low for GAP_LEN cycles, then enters IDLE with a DONE pulse.
  - CYCLE_CNT keeps only completed periods.
  - STOP during ABORT has no further effect.
  - STOP in IDLE is ignored.
- Phase counter: one down-counter of CNT_W bits, loaded with the clamped length on each state entry. The state advances when it reads 1.
- Immediate restart: START sampled on the DONE cycle (state IDLE) is accepted normally, so back-to-back bursts have no extra idle cycle.

Decomposition:
- Shared package twophase_pkg holds:
  - the state encoding enum (IDLE, PH1, GAP1, PH2, GAP2, ABORT)
  - default CNT_W and BURST_W constants
  - a clamp-to-one function used for all length fields
- One natural sub-module, phase_timer: a loadable CNT_W down-counter with load, enable and an expire flag (count==1). The FSM, config registers and cycle counter stay in twophase_sequencer.

Test Plan:
- Basic burst: PH1_LEN=3, GAP_LEN=1, PH2_LEN=2, NUM_CYCLES=2, START at edge 0.
  - PHI1 high on cycles 0–2, PHI2 high on cycles 4–5, PHI1 high again on cycles 7–9.
  - BUSY for 14 cycles, DONE pulse on cycle 14, CYCLE_CNT=2.
  - PHI1&PHI2 never both 1.
- Zero clamp: all lengths 0, NUM_CYCLES=1.
  - Pattern PHI1 1 cycle, gap 1, PHI2 1, gap 1.
  - DONE on cycle 4, no overlap.
- Abort mid-PH2: 3/1/2 config, NUM_CYCLES=0, STOP asserted during the second PH2 cycle of period 1.
  - Both phases low on the next edge, 1 ABORT cycle, then DONE.
  - CYCLE_CNT=0, BUSY drops with DONE.
- Config isolation: change PH1_LEN from 3 to 7 mid-burst. PHI1 width stays 3 for the whole burst; 7 applies only after the next START.
- Async reset mid-burst: RST_N pulsed low during PH1, between clock edges.
  - PHI1, BUSY and CYCLE_CNT go to 0 immediately.
  - No DONE pulse.
  - A new START after release runs normally.
- Continuous and restart:
  - NUM_CYCLES=0 with all lengths 1 runs 300 periods; CYCLE_CNT tracks the period count.
  - START held high through DONE restarts with PHI1 on the cycle after the DONE cycle.

Source files
------------

// File: rtl/twophase_pkg.sv
// Shared types and helpers for the two-phase clock sequencer.
// State encoding, default widths and the length clamp.
package twophase_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int BURST_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PH1,
    ST_GAP1,
    ST_PH2,
    ST_GAP2,
    ST_ABORT
  } state_e;

  function automatic logic [31:0] clamp1(
    input logic [31:0] v
  );
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/twophase_sequencer_phase_timer.sv
// Loadable down-counter timing each sequencer state.
// Expire flags the last cycle of the loaded length.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/twophase_sequencer.sv
// Programmable non-overlapping PHI1/PHI2 clock sequencer
// with burst/continuous modes and start/stop/done framing.
module twophase_sequencer
  import twophase_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               CLK_IN,
  input  logic               RST_N,
  input  logic               START,
  input  logic               STOP,
  input  logic [CNT_W-1:0]   PH1_LEN,
  input  logic [CNT_W-1:0]   PH2_LEN,
  input  logic [CNT_W-1:0]   GAP_LEN,
  input  logic [BURST_W-1:0] NUM_CYCLES,
  output logic               PHI1,
  output logic               PHI2,
  output logic               BUSY,
  output logic               DONE,
  output logic [BURST_W-1:0] CYCLE_CNT
);

  state_e state_q, state_d;
  logic phi1_q, phi1_d;
  logic phi2_q, phi2_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic [BURST_W-1:0] cyc_q, cyc_d;
  logic [BURST_W-1:0] cyc_inc;
  logic [CNT_W-1:0] ph1_q, ph1_d;
  logic [CNT_W-1:0] ph2_q, ph2_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [BURST_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] ph1_c, ph2_c, gap_c;
  logic ld;
  logic [CNT_W-1:0] ld_val;
  logic tmr_exp;

  assign ph1_c = CNT_W'(clamp1(32'(PH1_LEN)));
  assign ph2_c = CNT_W'(clamp1(32'(PH2_LEN)));
  assign gap_c = CNT_W'(clamp1(32'(GAP_LEN)));
  assign cyc_inc = cyc_q + BURST_W'(1);

  phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk(CLK_IN),
    .rst_n(RST_N),
    .load(ld),
    .load_val(ld_val),
    .en(busy_q),
    .expire(tmr_exp)
  );

  always_comb begin
    state_d = state_q;
    phi1_d  = phi1_q;
    phi2_d  = phi2_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cyc_d   = cyc_q;
    ph1_d   = ph1_q;
    ph2_d   = ph2_q;
    gap_d   = gap_q;
    num_d   = num_q;
    ld      = 1'b0;
    ld_val  = gap_q;
    unique case (state_q)
      ST_IDLE: begin
        if (START && !STOP) begin
          state_d = ST_PH1;
          phi1_d  = 1'b1;
          busy_d  = 1'b1;
          cyc_d   = '0;
          ph1_d   = ph1_c;
          ph2_d   = ph2_c;
          gap_d   = gap_c;
          num_d   = NUM_CYCLES;
          ld      = 1'b1;
          ld_val  = ph1_c;
        end
      end
      ST_PH1, ST_GAP1, ST_PH2, ST_GAP2: begin
        if (state_q == ST_GAP2 && tmr_exp) begin
          cyc_d = cyc_inc;
        end
        if (STOP) begin
          state_d = ST_ABORT;
          phi1_d  = 1'b0;
          phi2_d  = 1'b0;
          ld      = 1'b1;
          ld_val  = gap_q;
        end else if (tmr_exp) begin
          ld = 1'b1;
          if (state_q == ST_PH1) begin
            state_d = ST_GAP1;
            phi1_d  = 1'b0;
            ld_val  = gap_q;
          end else if (state_q == ST_GAP1) begin
            state_d = ST_PH2;
            phi2_d  = 1'b1;
            ld_val  = ph2_q;
          end else if (state_q == ST_PH2) begin
            state_d = ST_GAP2;
            phi2_d  = 1'b0;
            ld_val  = gap_q;
          end else if (num_q != '0 && cyc_inc == num_q) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_PH1;
            phi1_d  = 1'b1;
            ld_val  = ph1_q;
          end
        end
      end
      ST_ABORT: begin
        if (tmr_exp) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        phi1_d  = 1'b0;
        phi2_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      phi1_q  <= 1'b0;
      phi2_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cyc_q   <= '0;
      ph1_q   <= '0;
      ph2_q   <= '0;
      gap_q   <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      phi1_q  <= phi1_d;
      phi2_q  <= phi2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cyc_q   <= cyc_d;
      ph1_q   <= ph1_d;
      ph2_q   <= ph2_d;
      gap_q   <= gap_d;
      num_q   <= num_d;
    end
  end

  assign PHI1      = phi1_q;
  assign PHI2      = phi2_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign CYCLE_CNT = cyc_q;

endmodule
